// File: rtl/spi_pkg.sv
// Shared op encodings, sequencer states and parameter helpers for the SPI sequencer.
package spi_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_OE   = 2'b01;
  localparam logic [1:0] OP_XFER = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STROBE = 3'd1,
    GAP    = 3'd2,
    SETUP  = 3'd3,
    HIGH   = 3'd4,
    LOW    = 3'd5,
    FINISH = 3'd6
  } state_t;

  // A single slave still needs a one-bit index port.
  function automatic int cs_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_clkdiv.sv
// Half-period down-counter: ticks for one cycle each time it reaches zero, then reloads.
module spi_clkdiv
  import spi_pkg::*;
#(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DIV_W-1:0] reload,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // Count down; restart from the reload value on an explicit load or on expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= {DIV_W{1'b0}};
    end else if (load || (cnt == {DIV_W{1'b0}})) begin
      cnt <= reload;
    end else begin
      cnt <= cnt - DIV_W'(1);
    end
  end

  assign tick = (cnt == {DIV_W{1'b0}});

endmodule

// File: rtl/spi_sequencer.sv
// SPI mode-0 transfer sequencer with programmable SCLK divider, chip-select hold
// across words and a single-cycle output-enable strobe for the shift-register path.
module spi_sequencer
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 2,
  parameter int DIV_W  = 4,
  parameter int CS_W   = cs_width(NUM_CS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [CS_W-1:0]   cmd_cs,
  input  logic              cmd_hold,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [DIV_W-1:0]  div,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              oel,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] cs_l
);

  localparam int BW = $clog2(DATA_W + 1);

  state_t            state;
  logic [CS_W-1:0]   cs_r;
  logic              hold_r;
  logic              held_r;
  logic [DATA_W-1:0] sr;
  logic [BW-1:0]     bits_r;
  logic [DIV_W-1:0]  div_r;
  logic              first_r;
  logic              miso_r;
  logic              accept;
  logic              tick;
  logic              sample;
  logic [DIV_W-1:0]  reload;

  // Out-of-range indices select no slave, so those transfers clock dummy bits.
  function automatic logic [NUM_CS-1:0] cs_mask(input logic [CS_W-1:0] idx);
    logic [NUM_CS-1:0] m;
    m = {NUM_CS{1'b1}};
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(idx) == i) begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign reload    = accept ? div : div_r;
  // MISO is captured in the first HIGH cycle even when the phase is longer.
  assign sample    = first_r ? spi_miso : miso_r;

  spi_clkdiv #(.DIV_W(DIV_W)) u_clkdiv (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .reload (reload),
    .tick   (tick)
  );

  // Sequencer FSM with all pin-facing outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cs_r      <= {CS_W{1'b0}};
      hold_r    <= 1'b0;
      held_r    <= 1'b0;
      sr        <= {DATA_W{1'b0}};
      bits_r    <= {BW{1'b0}};
      div_r     <= {DIV_W{1'b0}};
      first_r   <= 1'b0;
      miso_r    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= {DATA_W{1'b0}};
      oel       <= 1'b1;
      spi_clk   <= 1'b0;
      spi_mosi  <= 1'b0;
      cs_l      <= {NUM_CS{1'b1}};
    end else begin
      rsp_valid <= 1'b0;
      first_r   <= tick;
      case (state)
        IDLE: begin
          oel <= 1'b1;
          if (accept) begin
            first_r <= 1'b1;
            case (cmd_op)
              OP_OE: begin
                state <= STROBE;
                oel   <= 1'b0;
              end
              OP_XFER: begin
                cs_r    <= cmd_cs;
                hold_r  <= cmd_hold;
                sr      <= cmd_data;
                bits_r  <= BW'(DATA_W);
                div_r   <= div;
                spi_clk <= 1'b0;
                // Switching slaves while one is held needs a deselect gap first.
                if (held_r && (cmd_cs != cs_r)) begin
                  state  <= GAP;
                  cs_l   <= {NUM_CS{1'b1}};
                  held_r <= 1'b0;
                end else begin
                  state    <= SETUP;
                  cs_l     <= cs_mask(cmd_cs);
                  spi_mosi <= cmd_data[DATA_W-1];
                end
              end
              default: begin
                state <= IDLE;
              end
            endcase
          end
        end
        STROBE: begin
          oel   <= 1'b1;
          state <= IDLE;
        end
        GAP: begin
          if (tick) begin
            state    <= SETUP;
            cs_l     <= cs_mask(cs_r);
            spi_mosi <= sr[DATA_W-1];
          end
        end
        SETUP: begin
          if (tick) begin
            state   <= HIGH;
            spi_clk <= 1'b1;
          end
        end
        HIGH: begin
          if (first_r) begin
            miso_r <= spi_miso;
          end
          if (tick) begin
            sr      <= {sr[DATA_W-2:0], sample};
            bits_r  <= bits_r - BW'(1);
            spi_clk <= 1'b0;
            if (bits_r != BW'(1)) begin
              state    <= LOW;
              spi_mosi <= sr[DATA_W-2];
            end else begin
              state <= FINISH;
            end
          end
        end
        LOW: begin
          if (tick) begin
            state   <= HIGH;
            spi_clk <= 1'b1;
          end
        end
        FINISH: begin
          if (tick) begin
            state     <= IDLE;
            rsp_valid <= 1'b1;
            rsp_data  <= sr;
            held_r    <= hold_r && (int'(cs_r) < NUM_CS);
            if (!hold_r) begin
              cs_l <= {NUM_CS{1'b1}};
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
